// File: rtl/mem_responder_pkg.sv
// Shared memory-interface widths, responder state encodings and stall LFSR step.
// Interface macros keep their existing values when already defined.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 28
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 5
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
`ifndef MEM_DATA_CYCLES
`define MEM_DATA_CYCLES 4
`endif
`ifndef MEMR_IDLE
`define MEMR_IDLE  2'd0
`define MEMR_WDATA 2'd1
`define MEMR_RWAIT 2'd2
`define MEMR_RRESP 2'd3
`endif

package mem_responder_pkg;
  localparam int MEM_ADDR_W = `MEM_ADDR_BITS;
  localparam int MEM_TAG_W  = `MEM_TAG_BITS;
  localparam int MEM_DATA_W = `MEM_DATA_BITS;
  localparam int MEM_MASK_W = `MEM_DATA_BITS / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = `MEMR_IDLE,
    ST_WDATA = `MEMR_WDATA,
    ST_RWAIT = `MEMR_RWAIT,
    ST_RRESP = `MEMR_RRESP
  } memr_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR, taps 16/14/13/11 (maximal length).
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
endpackage

// File: rtl/mem_responder_array.sv
// Line storage for mem_responder: byte-masked write port, registered read port.
module mem_responder_array #(
  parameter int ROWS   = 4096,
  parameter int DATA_W = 128,
  parameter int ROW_W  = $clog2(ROWS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [ROW_W-1:0]    waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wmask,
  input  logic                re,
  input  logic [ROW_W-1:0]    raddr,
  output logic [DATA_W-1:0]   rdata
);
  logic [DATA_W-1:0] mem [ROWS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (wmask[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Only the read register is cleared; stored lines survive reset.
  always_ff @(posedge clk) begin
    if (!reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/mem_responder.sv
// Behavioural main-memory slave for the mem_req / mem_req_data / mem_resp interface.
// Optional macro MEM_RESPONDER_RAND_STALL_EN adds LFSR-driven ready stalls.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int LATENCY     = 4,
  parameter int DATA_CYCLES = `MEM_DATA_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_req_valid,
  output logic                  mem_req_ready,
  input  logic                  mem_req_rw,
  input  logic [MEM_ADDR_W-1:0] mem_req_addr,
  input  logic [MEM_TAG_W-1:0]  mem_req_tag,
  input  logic                  mem_req_data_valid,
  output logic                  mem_req_data_ready,
  input  logic [MEM_DATA_W-1:0] mem_req_data_bits,
  input  logic [MEM_MASK_W-1:0] mem_req_data_mask,
  output logic                  mem_resp_valid,
  output logic [MEM_TAG_W-1:0]  mem_resp_tag,
  output logic [MEM_DATA_W-1:0] mem_resp_data
);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int ROWS   = DEPTH * DATA_CYCLES;
  localparam int ROW_W  = $clog2(ROWS);
  localparam int BEAT_W = $clog2(DATA_CYCLES + 1);
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  memr_state_e          state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [MEM_TAG_W-1:0] tag_q;
  logic [BEAT_W-1:0]    beat_q;
  logic [LAT_W-1:0]     lat_q;
  logic [ROW_W-1:0]     row;
  logic                 req_acc, wbeat_acc, rd_en, stall_nxt;
  logic                 vld_p1;
  logic [MEM_TAG_W-1:0] tag_p1;
  logic [MEM_DATA_W-1:0] rd_data_p1;
  logic                 addr_hi_unused;

  assign addr_hi_unused = ^mem_req_addr[MEM_ADDR_W-1:IDX_W];

`ifdef MEM_RESPONDER_RAND_STALL_EN
  logic [15:0] lfsr_q, lfsr_nxt;
  assign lfsr_nxt  = lfsr_step(lfsr_q);
  // Readies are registered, so they are gated by the LFSR value they will coexist with.
  assign stall_nxt = (lfsr_nxt[1:0] == 2'b00);
  always_ff @(posedge clk) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_nxt;
  end
`else
  assign stall_nxt = 1'b0;
`endif

  assign req_acc   = mem_req_valid & mem_req_ready;
  assign wbeat_acc = mem_req_data_valid & mem_req_data_ready & (state_q == ST_WDATA);
  assign rd_en     = (state_q == ST_RRESP) && (beat_q != BEAT_W'(DATA_CYCLES));
  assign row       = ROW_W'(idx_q) * ROW_W'(DATA_CYCLES) + ROW_W'(beat_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q            <= ST_IDLE;
      beat_q             <= '0;
      lat_q              <= '0;
      mem_req_ready      <= 1'b0;
      mem_req_data_ready <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mem_req_ready <= !stall_nxt;
          if (req_acc) begin
            idx_q         <= mem_req_addr[IDX_W-1:0];
            tag_q         <= mem_req_tag;
            beat_q        <= '0;
            mem_req_ready <= 1'b0;
            if (mem_req_rw) begin
              state_q            <= ST_WDATA;
              mem_req_data_ready <= !stall_nxt;
            end else begin
              state_q <= ST_RWAIT;
              lat_q   <= LAT_W'(LATENCY - 1);
            end
          end
        end
        ST_WDATA: begin
          mem_req_data_ready <= !stall_nxt;
          if (wbeat_acc) begin
            if (beat_q == BEAT_W'(DATA_CYCLES - 1)) begin
              state_q            <= ST_IDLE;
              mem_req_data_ready <= 1'b0;
              mem_req_ready      <= !stall_nxt;
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
        ST_RWAIT: begin
          if (lat_q == '0) state_q <= ST_RRESP;
          else             lat_q   <= lat_q - LAT_W'(1);
        end
        ST_RRESP: begin
          // beat_q runs one past the last read so ready rises only after the final beat is out.
          if (beat_q == BEAT_W'(DATA_CYCLES)) begin
            state_q       <= ST_IDLE;
            mem_req_ready <= !stall_nxt;
          end else begin
            beat_q <= beat_q + BEAT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---- p0 -> p1: array read register and response qualifiers ----
  mem_responder_array #(
    .ROWS   (ROWS),
    .DATA_W (MEM_DATA_W),
    .ROW_W  (ROW_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (wbeat_acc),
    .waddr (row),
    .wdata (mem_req_data_bits),
    .wmask (mem_req_data_mask),
    .re    (rd_en),
    .raddr (row),
    .rdata (rd_data_p1)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      tag_p1 <= '0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) tag_p1 <= tag_q;
    end
  end

  assign mem_resp_valid = vld_p1;
  assign mem_resp_tag   = tag_p1;
  assign mem_resp_data  = rd_data_p1;
endmodule

// File: tb/tb_mem_responder.sv
// Directed + scoreboard bench for mem_responder: expected read beats queued at request accept.
`timescale 1ns/1ps
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int LAT = 4;
  localparam int NB  = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  mem_req_valid = 1'b0;
  logic                  mem_req_ready;
  logic                  mem_req_rw = 1'b0;
  logic [MEM_ADDR_W-1:0] mem_req_addr = '0;
  logic [MEM_TAG_W-1:0]  mem_req_tag = '0;
  logic                  mem_req_data_valid = 1'b0;
  logic                  mem_req_data_ready;
  logic [MEM_DATA_W-1:0] mem_req_data_bits = '0;
  logic [MEM_MASK_W-1:0] mem_req_data_mask = '0;
  logic                  mem_resp_valid;
  logic [MEM_TAG_W-1:0]  mem_resp_tag;
  logic [MEM_DATA_W-1:0] mem_resp_data;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(1024), .LATENCY(LAT), .DATA_CYCLES(NB)) dut (
    .clk                (clk),
    .reset              (reset),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_rw         (mem_req_rw),
    .mem_req_addr       (mem_req_addr),
    .mem_req_tag        (mem_req_tag),
    .mem_req_data_valid (mem_req_data_valid),
    .mem_req_data_ready (mem_req_data_ready),
    .mem_req_data_bits  (mem_req_data_bits),
    .mem_req_data_mask  (mem_req_data_mask),
    .mem_resp_valid     (mem_resp_valid),
    .mem_resp_tag       (mem_resp_tag),
    .mem_resp_data      (mem_resp_data)
  );

  typedef struct {
    logic [MEM_TAG_W-1:0]  tag;
    logic [MEM_DATA_W-1:0] data;
    int                    cyc;
  } exp_t;

  exp_t                  sb[$];
  logic [MEM_DATA_W-1:0] mdl [int];
  logic [MEM_DATA_W-1:0] wd [NB];
  logic [MEM_MASK_W-1:0] wm [NB];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

`ifdef MEM_RESPONDER_RAND_STALL_EN
  logic [15:0] lfsr_m;
  always @(posedge clk) begin
    if (!reset) lfsr_m <= 16'hACE1;
    else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end
  always @(negedge clk) begin
    if (lfsr_m[1:0] == 2'b00) begin
      chk("stall_req_ready", 128'(mem_req_ready), 128'd0);
      chk("stall_data_ready", 128'(mem_req_data_ready), 128'd0);
    end
  end
  function automatic logic exp_rdy();
    return lfsr_m[1:0] != 2'b00;
  endfunction
`else
  function automatic logic exp_rdy();
    return 1'b1;
  endfunction
`endif

  // Response monitor: every beat must match the head of the scoreboard, cycle-exact.
  always @(negedge clk) begin
    exp_t e;
    if (mem_resp_valid === 1'b1) begin
      chk("resp_expected", 128'(sb.size() != 0), 128'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("resp_tag", 128'(mem_resp_tag), 128'(e.tag));
        chk("resp_data", mem_resp_data, e.data);
        chk("resp_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  task automatic do_req(input logic rw, input logic [MEM_ADDR_W-1:0] addr,
                        input logic [MEM_TAG_W-1:0] tag, output int acc);
    bit ok;
    @(negedge clk);
    mem_req_valid = 1'b1;
    mem_req_rw    = rw;
    mem_req_addr  = addr;
    mem_req_tag   = tag;
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      if (mem_req_ready === 1'b1) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("req_accept", 128'(ok), 128'd1);
    @(negedge clk);
    mem_req_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic do_write(input logic [MEM_ADDR_W-1:0] addr, input logic [MEM_TAG_W-1:0] tag,
                          input int stall_after);
    int acc;
    int r;
    bit ok;
    logic [MEM_DATA_W-1:0] cur;
    do_req(1'b1, addr, tag, acc);
    for (int b = 0; b < NB; b++) begin
      mem_req_data_valid = 1'b1;
      mem_req_data_bits  = wd[b];
      mem_req_data_mask  = wm[b];
      ok = 0;
      for (int n = 0; n < 200; n++) begin
        if (mem_req_data_ready === 1'b1) begin
          @(posedge clk);
          ok = 1;
          break;
        end
        @(negedge clk);
      end
      chk("wbeat_accept", 128'(ok), 128'd1);
      r = int'(addr[9:0]) * NB + b;
      cur = mdl.exists(r) ? mdl[r] : 'x;
      for (int i = 0; i < MEM_MASK_W; i++)
        if (wm[b][i]) cur[8*i +: 8] = wd[b][8*i +: 8];
      mdl[r] = cur;
      @(negedge clk);
      mem_req_data_valid = 1'b0;
      if (b == stall_after) begin
        for (int s = 0; s < 3; s++) begin
          chk("stall_req_ready_low", 128'(mem_req_ready), 128'd0);
`ifndef MEM_RESPONDER_RAND_STALL_EN
          chk("stall_wdata_held", 128'(mem_req_data_ready), 128'd1);
`endif
          @(negedge clk);
        end
      end
    end
    chk("write_done_ready", 128'(mem_req_ready), 128'(exp_rdy()));
  endtask

  task automatic do_read(input logic [MEM_ADDR_W-1:0] addr, input logic [MEM_TAG_W-1:0] tag,
                         input bit push);
    int acc;
    exp_t e;
    do_req(1'b0, addr, tag, acc);
    if (push) begin
      for (int b = 0; b < NB; b++) begin
        e.tag  = tag;
        e.data = mdl[int'(addr[9:0]) * NB + b];
        e.cyc  = acc + LAT + 1 + b;
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("sb_drained", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MEM_ADDR_W-1:0] ra;
    int ntx;

    // Reset state
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 128'(mem_req_ready), 128'd0);
    chk("rst_data_ready", 128'(mem_req_data_ready), 128'd0);
    chk("rst_resp_valid", 128'(mem_resp_valid), 128'd0);
    chk("rst_resp_tag", 128'(mem_resp_tag), 128'd0);
    chk("rst_resp_data", mem_resp_data, 128'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 128'(mem_req_ready), 128'(exp_rdy()));
    chk("idle_data_ready", 128'(mem_req_data_ready), 128'd0);

    // Stray write data in IDLE is not consumed
    mem_req_data_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_data_ignored", 128'(mem_req_data_ready), 128'd0);
    end
    mem_req_data_valid = 1'b0;

    // Write then read, latency check
    for (int b = 0; b < NB; b++) begin wd[b] = 128'(b + 1); wm[b] = '1; end
    do_write(28'h10, 5'd3, -1);
    do_read(28'h10, 5'd7, 1'b1);
    drain();

    // Byte mask over an all-0xFF line
    for (int b = 0; b < NB; b++) begin wd[b] = '1; wm[b] = '1; end
    do_write(28'h10, 5'd1, -1);
    for (int b = 0; b < NB; b++) begin wd[b] = '0; wm[b] = '0; end
    wm[0] = 16'h0001;
    do_write(28'h10, 5'd2, -1);
    do_read(28'h10, 5'd4, 1'b1);
    drain();

    // Data stalled mid-line
    for (int b = 0; b < NB; b++) begin wd[b] = {4{32'hC0DE_0000 + 32'(b)}}; wm[b] = '1; end
    do_write(28'h20, 5'd6, 1);
    do_read(28'h20, 5'd8, 1'b1);
    drain();

    // Aliasing modulo DEPTH
    for (int b = 0; b < NB; b++) begin wd[b] = {4{32'hA11A_5000 + 32'(b)}}; wm[b] = '1; end
    do_write(28'h400, 5'd10, -1);
    do_read(28'h000, 5'd11, 1'b1);
    drain();

    // Reset during RWAIT abandons the read
    do_read(28'h10, 5'd5, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_resp_valid", 128'(mem_resp_valid), 128'd0);
    chk("midrst_req_ready", 128'(mem_req_ready), 128'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 128'(mem_req_ready), 128'(exp_rdy()));
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("no_resp_after_reset", 128'(mem_resp_valid), 128'd0);
    end
    do_read(28'h10, 5'd9, 1'b1);
    drain();

    // Random mix over the lines already written
`ifdef MEM_RESPONDER_RAND_STALL_EN
    ntx = 100;
`else
    ntx = 24;
`endif
    for (int t = 0; t < ntx; t++) begin
      ra = 28'($urandom);
      case ($urandom_range(0, 2))
        0:       ra[9:0] = 10'h010;
        1:       ra[9:0] = 10'h020;
        default: ra[9:0] = 10'h000;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < NB; b++) begin
          wd[b] = {$urandom, $urandom, $urandom, $urandom};
          case ($urandom_range(0, 2))
            0:       wm[b] = '0;
            1:       wm[b] = '1;
            default: wm[b] = 16'($urandom);
          endcase
        end
        do_write(ra, 5'($urandom), -1);
      end else begin
        do_read(ra, 5'($urandom), 1'b1);
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
